// File: rtl/arm_multicycle_controller_if.sv
// Control/status bundle between the ARM multicycle controller
// (master) and the datapath it sequences (slave).
interface arm_multicycle_controller_if #(
  parameter int ALUCTRL_W = 3
);
  logic [31:4]          Instr;
  logic [3:0]           ALUFlags;
  logic                 PCWrite;
  logic                 MemWrite;
  logic                 RegWrite;
  logic                 IRWrite;
  logic                 AdrSrc;
  logic [1:0]           RegSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ResultSrc;
  logic [1:0]           ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 Undef;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite,
    output AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
    output ResultSrc, ImmSrc, ALUControl, Undef
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite,
    input  AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
    input  ResultSrc, ImmSrc, ALUControl, Undef
  );
endinterface

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: main FSM, ALU decode and a
// registered condition/flags unit that gates architectural writes.
module arm_multicycle_controller #(
  parameter int ALUCTRL_W = 3,
  parameter bit MUL_EN    = 1'b1
) (
  input logic clk,
  input logic reset,
  arm_multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, EXECUTEM, ALUWB, BRANCH
  } state_t;

  state_t     state;
  state_t     dec_next;
  logic [3:0] flags;
  logic       condexreg;

  logic [3:0] cond;
  logic [3:0] rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       is_mul;
  logic       undef;
  logic       unused_instr;

  assign cond   = bus.Instr[31:28];
  assign op     = bus.Instr[27:26];
  assign funct  = bus.Instr[25:20];
  assign rd     = bus.Instr[15:12];
  assign is_mul = (op == 2'b00)
               && (funct[5:1] == 5'b00000)
               && (bus.Instr[7:4] == 4'b1001);
  assign undef  = (op == 2'b11) || (is_mul && !MUL_EN);
  assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:8]};

  logic n, z, c, v;
  logic condex;

  assign {n, z, c, v} = flags;

  always_comb begin
    condex = 1'b0;
    case (cond)
      4'h0:    condex = z;
      4'h1:    condex = ~z;
      4'h2:    condex = c;
      4'h3:    condex = ~c;
      4'h4:    condex = n;
      4'h5:    condex = ~n;
      4'h6:    condex = v;
      4'h7:    condex = ~v;
      4'h8:    condex = c & ~z;
      4'h9:    condex = ~c | z;
      4'hA:    condex = (n == v);
      4'hB:    condex = (n != v);
      4'hC:    condex = ~z & (n == v);
      4'hD:    condex = z | (n != v);
      4'hE:    condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // known: recognised op (S may set N,Z); arith: S may also set C,V
  logic [1:0] aluop;
  logic       nowrite;
  logic       known;
  logic       arith;

  always_comb begin
    aluop   = 2'd0;
    nowrite = 1'b1;
    known   = 1'b0;
    arith   = 1'b0;
    case (funct[4:1])
      4'b0100: begin
        nowrite = 1'b0; known = 1'b1; arith = 1'b1;
      end
      4'b0010: begin
        aluop = 2'd1; nowrite = 1'b0;
        known = 1'b1; arith = 1'b1;
      end
      4'b0000: begin
        aluop = 2'd2; nowrite = 1'b0; known = 1'b1;
      end
      4'b1100: begin
        aluop = 2'd3; nowrite = 1'b0; known = 1'b1;
      end
      4'b1010: begin
        aluop = 2'd1; known = 1'b1; arith = 1'b1;
      end
      default: ;
    endcase
  end

  logic [1:0] flagw;

  always_comb begin
    flagw = 2'b00;
    if (state == EXECUTEM)
      flagw = {funct[0], 1'b0};
    else if (state == EXECUTER || state == EXECUTEI)
      flagw = {funct[0] & known, funct[0] & arith};
  end

  always_comb begin
    if (op == 2'b01)      dec_next = MEMADR;
    else if (op == 2'b10) dec_next = BRANCH;
    else if (undef)       dec_next = FETCH;
    else if (funct[5])    dec_next = EXECUTEI;
    else if (is_mul)      dec_next = EXECUTEM;
    else                  dec_next = EXECUTER;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      flags     <= 4'b0000;
      condexreg <= 1'b0;
    end else begin
      if (state == DECODE)
        condexreg <= condex;
      if (condexreg) begin
        if (flagw[1]) flags[3:2] <= bus.ALUFlags[3:2];
        if (flagw[0]) flags[1:0] <= bus.ALUFlags[1:0];
      end
      case (state)
        FETCH:    state <= DECODE;
        DECODE:   state <= dec_next;
        MEMADR:   state <= funct[0] ? MEMRD : MEMWR;
        MEMRD:    state <= MEMWB;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        EXECUTEM: state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  logic                 pcw, memw, regw, irw, adr, rs0, und;
  logic [1:0]           srca, srcb, res;
  logic [ALUCTRL_W-1:0] alu;

  always_comb begin
    pcw  = 1'b0; memw = 1'b0; regw = 1'b0;
    irw  = 1'b0; adr  = 1'b0; rs0  = 1'b0;
    und  = 1'b0; srca = 2'b00; srcb = 2'b00;
    res  = 2'b00; alu = '0;
    case (state)
      FETCH: begin
        irw = 1'b1; pcw = 1'b1;
        srca = 2'b01; srcb = 2'b10; res = 2'b10;
      end
      DECODE: begin
        srca = 2'b01; srcb = 2'b10; res = 2'b10;
        und = undef;
      end
      MEMADR: srcb = 2'b01;
      MEMRD:  adr = 1'b1;
      MEMWB: begin
        res  = 2'b01;
        regw = condexreg;
        pcw  = condexreg & (rd == 4'hF);
      end
      MEMWR: begin
        adr = 1'b1; memw = condexreg;
      end
      EXECUTER: alu = ALUCTRL_W'(aluop);
      EXECUTEI: begin
        srcb = 2'b01; alu = ALUCTRL_W'(aluop);
      end
      EXECUTEM: alu = ALUCTRL_W'(3'd4);
      ALUWB: begin
        regw = condexreg & ~nowrite;
        pcw  = condexreg & ~nowrite & (rd == 4'hF);
      end
      BRANCH: begin
        srcb = 2'b01; rs0 = 1'b1;
        res  = 2'b10; pcw = condexreg;
      end
      default: ;
    endcase
  end

  // a low reset aborts the current state, so no enable may leak out
  assign bus.PCWrite    = pcw  & reset;
  assign bus.MemWrite   = memw & reset;
  assign bus.RegWrite   = regw & reset;
  assign bus.IRWrite    = irw  & reset;
  assign bus.Undef      = und  & reset;
  assign bus.AdrSrc     = adr;
  assign bus.RegSrc     = {(op == 2'b01) && !funct[0], rs0};
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ResultSrc  = res;
  assign bus.ImmSrc     = op;
  assign bus.ALUControl = alu;
endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Bench for arm_multicycle_controller: directed table, random
// instruction stream against a reference model, reset/MUL corners.
module tb_arm_multicycle_controller;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  arm_multicycle_controller_if #(.ALUCTRL_W(3)) bus0 ();
  arm_multicycle_controller_if #(.ALUCTRL_W(3)) bus1 ();

  arm_multicycle_controller #(
    .ALUCTRL_W(3), .MUL_EN(1'b1)
  ) u0 (.clk(clk), .reset(reset), .bus(bus0));

  arm_multicycle_controller #(
    .ALUCTRL_W(3), .MUL_EN(1'b0)
  ) u1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct packed {
    logic       pcw, memw, regw, irw, adr;
    logic [1:0] regsrc, srca, srcb, res, imm;
    logic [2:0] alu;
    logic       und;
  } outv_t;

  typedef enum {
    C_DP, C_DPI, C_MUL, C_LDR, C_STR, C_B, C_UND
  } cls_e;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  alf;
    int          reg_n, mem_n, pc_n, und_n;
  } vec_t;

  outv_t       got0;
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] prevw;
  logic [3:0]  mflags;

  assign got0 = {bus0.PCWrite, bus0.MemWrite, bus0.RegWrite,
                 bus0.IRWrite, bus0.AdrSrc, bus0.RegSrc,
                 bus0.ALUSrcA, bus0.ALUSrcB, bus0.ResultSrc,
                 bus0.ImmSrc, bus0.ALUControl, bus0.Undef};

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cls_e classify(input logic [31:0] w,
                                    input logic mul_en);
    if (w[27:26] == 2'b11) return C_UND;
    if (w[27:26] == 2'b01) return w[20] ? C_LDR : C_STR;
    if (w[27:26] == 2'b10) return C_B;
    if (w[25]) return C_DPI;
    if (w[25:21] == 5'd0 && w[7:4] == 4'b1001)
      return mul_en ? C_MUL : C_UND;
    return C_DP;
  endfunction

  // ARM condition: even code = base test, odd code = its negation
  function automatic logic cond_pass(input logic [3:0] cd,
                                     input logic [3:0] f);
    logic nf, zf, cf, vf, base;
    {nf, zf, cf, vf} = f;
    if (cd == 4'hE) return 1'b1;
    if (cd == 4'hF) return 1'b0;
    case (cd[3:1])
      3'd0: base = zf;
      3'd1: base = cf;
      3'd2: base = nf;
      3'd3: base = vf;
      3'd4: base = cf && !zf;
      3'd5: base = (nf == vf);
      default: base = !zf && (nf == vf);
    endcase
    return cd[0] ? !base : base;
  endfunction

  function automatic void dp_info(input logic [3:0] cmd,
                                  output logic [2:0] ctl,
                                  output logic wr,
                                  output logic kn,
                                  output logic ar);
    ctl = 3'd0; wr = 1'b0; kn = 1'b0; ar = 1'b0;
    case (cmd)
      4'b0100: begin ctl = 3'd0; wr = 1'b1; kn = 1'b1; ar = 1'b1; end
      4'b0010: begin ctl = 3'd1; wr = 1'b1; kn = 1'b1; ar = 1'b1; end
      4'b0000: begin ctl = 3'd2; wr = 1'b1; kn = 1'b1; end
      4'b1100: begin ctl = 3'd3; wr = 1'b1; kn = 1'b1; end
      4'b1010: begin ctl = 3'd1; kn = 1'b1; ar = 1'b1; end
      default: ;
    endcase
  endfunction

  // expected outputs in cycle k of an instruction (k=0 is its fetch)
  function automatic outv_t model_out(input cls_e cls, input int k,
                                      input logic [31:0] w,
                                      input logic [31:0] pw,
                                      input logic pass);
    outv_t       e;
    logic [31:0] cur;
    logic [2:0]  ctl;
    logic        wr, kn, ar;
    e   = '0;
    cur = (k == 0) ? pw : w;
    e.imm       = cur[27:26];
    e.regsrc[1] = (cur[27:26] == 2'b01) && !cur[20];
    dp_info(w[24:21], ctl, wr, kn, ar);
    if (k == 0) begin
      e.irw = 1'b1; e.pcw = 1'b1;
      e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10;
    end else if (k == 1) begin
      e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10;
      e.und  = (cls == C_UND);
    end else begin
      case (cls)
        C_LDR, C_STR: begin
          if (k == 2) e.srcb = 2'b01;
          if (k == 3) begin
            e.adr  = 1'b1;
            e.memw = (cls == C_STR) && pass;
          end
          if (k == 4) begin
            e.res  = 2'b01;
            e.regw = pass;
            e.pcw  = pass && (w[15:12] == 4'hF);
          end
        end
        C_DP, C_DPI, C_MUL: begin
          if (k == 2) begin
            e.srcb = (cls == C_DPI) ? 2'b01 : 2'b00;
            e.alu  = (cls == C_MUL) ? 3'd4 : ctl;
          end
          if (k == 3) begin
            e.regw = pass && wr;
            e.pcw  = pass && wr && (w[15:12] == 4'hF);
          end
        end
        C_B: begin
          e.srcb = 2'b01; e.regsrc[0] = 1'b1;
          e.res  = 2'b10; e.pcw = pass;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic run_instr(input logic [31:0] w,
                           input logic [3:0] alf,
                           input logic rnd,
                           output int nreg, output int nmem,
                           output int npc, output int nund);
    cls_e       cls;
    logic       pass, wr, kn, ar;
    logic [2:0] ctl;
    logic [3:0] af;
    int         ncyc;
    cls  = classify(w, 1'b1);
    ncyc = (cls == C_UND) ? 2 : (cls == C_B) ? 3 :
           (cls == C_LDR) ? 5 : 4;
    nreg = 0; nmem = 0; npc = 0; nund = 0;
    dp_info(w[24:21], ctl, wr, kn, ar);
    check("fetch", 32'(got0), 32'(model_out(cls, 0, w, prevw, 1'b0)));
    pass = cond_pass(w[31:28], mflags);
    for (int k = 1; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus0.Instr = w[31:4];
      af = rnd ? 4'($urandom) : alf;
      bus0.ALUFlags = af;
      #1;
      check($sformatf("cyc%0d_%h", k, w), 32'(got0),
            32'(model_out(cls, k, w, prevw, pass)));
      nreg += int'(got0.regw);
      nmem += int'(got0.memw);
      npc  += int'(got0.pcw);
      nund += int'(got0.und);
      if (k == 2 && pass && w[20]) begin
        if (cls == C_MUL) mflags[3:2] = af[3:2];
        if ((cls == C_DP || cls == C_DPI) && kn) mflags[3:2] = af[3:2];
        if ((cls == C_DP || cls == C_DPI) && ar) mflags[1:0] = af[1:0];
      end
    end
    @(posedge clk);
    #1;
    bus0.ALUFlags = rnd ? 4'($urandom) : alf;
    #1;
    check("refetch", 32'(bus0.IRWrite), 32'd1);
    prevw = w;
  endtask

  function automatic logic [3:0] pick_cmd();
    case ($urandom_range(0, 5))
      0: return 4'b0100;
      1: return 4'b0010;
      2: return 4'b0000;
      3: return 4'b1100;
      4: return 4'b1010;
      default: return 4'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: begin w[27:25] = 3'b000; w[24:21] = pick_cmd(); end
      1: begin w[27:25] = 3'b001; w[24:21] = pick_cmd(); end
      2: begin w[27:21] = 7'd0; w[7:4] = 4'b1001; end
      3, 4: w[27:26] = 2'b01;
      5: w[27:26] = 2'b10;
      default: w[27:26] = 2'b11;
    endcase
    return w;
  endfunction

  vec_t tbl[12];

  initial begin
    int a, b, c, d;
    logic [31:0] w;

    tbl[0]  = '{32'hE0821003, 4'hF, 1, 0, 0, 0}; // ADD R1,R2,R3
    tbl[1]  = '{32'h0A000000, 4'h0, 0, 0, 0, 0}; // BEQ, Z=0
    tbl[2]  = '{32'hE0500000, 4'h4, 1, 0, 0, 0}; // SUBS -> Z
    tbl[3]  = '{32'h0A000000, 4'h0, 0, 0, 1, 0}; // BEQ taken
    tbl[4]  = '{32'h15801000, 4'h0, 0, 0, 0, 0}; // STRNE, Z=1
    tbl[5]  = '{32'hE5901000, 4'h0, 1, 0, 0, 0}; // LDR
    tbl[6]  = '{32'hE0000291, 4'h0, 1, 0, 0, 0}; // MUL
    tbl[7]  = '{32'hEC000000, 4'h0, 0, 0, 0, 1}; // op=11
    tbl[8]  = '{32'hE3500000, 4'h2, 0, 0, 0, 0}; // CMP -> C
    tbl[9]  = '{32'h2A000000, 4'h0, 0, 0, 1, 0}; // BCS taken
    tbl[10] = '{32'h0A000000, 4'h0, 0, 0, 0, 0}; // BEQ, Z=0
    tbl[11] = '{32'hE081F002, 4'h0, 1, 0, 1, 0}; // ADD PC

    reset = 1'b0;
    bus0.Instr = '0; bus0.ALUFlags = '0;
    bus1.Instr = '0; bus1.ALUFlags = '0;
    prevw  = '0;
    mflags = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'({bus0.PCWrite, bus0.MemWrite,
          bus0.RegWrite, bus0.IRWrite}), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_fetch", 32'({bus0.IRWrite, bus0.PCWrite}), 32'd3);

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].w, tbl[i].alf, 1'b0, a, b, c, d);
      check($sformatf("t%0d_reg", i), 32'(a), 32'(tbl[i].reg_n));
      check($sformatf("t%0d_mem", i), 32'(b), 32'(tbl[i].mem_n));
      check($sformatf("t%0d_pc", i),  32'(c), 32'(tbl[i].pc_n));
      check($sformatf("t%0d_und", i), 32'(d), 32'(tbl[i].und_n));
    end

    for (int i = 0; i < 300; i++)
      run_instr(rand_instr(), 4'h0, 1'b1, a, b, c, d);

    // set all flags, then abort a store in MEMWR
    run_instr(32'hE3500000, 4'hF, 1'b0, a, b, c, d);
    w = 32'hE5801000;
    @(posedge clk); #1 bus0.Instr = w[31:4]; #1;
    @(posedge clk); #2;
    @(posedge clk); #1 reset = 1'b0; #1;
    check("abort_adr", 32'(bus0.AdrSrc), 32'd1);
    check("abort_we", 32'({bus0.PCWrite, bus0.MemWrite,
          bus0.RegWrite, bus0.IRWrite}), 32'd0);
    @(posedge clk); #1 reset = 1'b1; #1;
    check("abort_fetch", 32'(bus0.IRWrite), 32'd1);
    mflags = '0;
    prevw  = w;
    run_instr(32'h0A000000, 4'h0, 1'b0, a, b, c, d);
    check("abort_flags_beq", 32'(c), 32'd0);

    // MUL with the multiplier path disabled
    @(posedge clk); #1 reset = 1'b0; #1;
    @(posedge clk); #1 reset = 1'b1; #1;
    check("m0_fetch", 32'(bus1.IRWrite), 32'd1);
    w = 32'hE0000291;
    @(posedge clk); #1 bus1.Instr = w[31:4]; #1;
    check("m0_undef", 32'(bus1.Undef), 32'd1);
    check("m0_we", 32'({bus1.PCWrite, bus1.MemWrite,
          bus1.RegWrite, bus1.IRWrite}), 32'd0);
    @(posedge clk); #2;
    check("m0_back", 32'(bus1.IRWrite), 32'd1);
    check("m0_undef_end", 32'(bus1.Undef), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
